// File: rtl/crypto_pkg.sv
// ============================================================================
// Module : crypto_pkg
// Brief  : Constants shared by the crypto classifier and the crypto stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package crypto_pkg;

    localparam int ENC_BIT = 32;

    // Bit offsets into a 256-bit beat where byte 0 sits at tdata[255:248]
    localparam int ETYPE_MSB      = 159;
    localparam int ETYPE_LSB      = 144;
    localparam int PROTO_MSB      = 71;
    localparam int PROTO_LSB      = 64;
    localparam int PROTO_STRB_IDX = 8;

    localparam logic [15:0] DEFAULT_ETYPE = 16'h0800;

    localparam logic [0:0] HEAD = 1'b0;
    localparam logic [0:0] BODY = 1'b1;

endpackage

`default_nettype wire

// File: rtl/axis_reg_slice.sv
// ============================================================================
// Module : axis_reg_slice
// Brief  : Single-stage AXI4-Stream register slice, full throughput.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axis_reg_slice #(
    parameter int DATA_WIDTH = 256,
    parameter int USER_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   i_tdata,
    input  logic [DATA_WIDTH/8-1:0] i_tstrb,
    input  logic [USER_WIDTH-1:0]   i_tuser,
    input  logic                    i_tlast,
    input  logic                    i_tvalid,
    output logic                    o_tready,
    output logic [DATA_WIDTH-1:0]   o_tdata,
    output logic [DATA_WIDTH/8-1:0] o_tstrb,
    output logic [USER_WIDTH-1:0]   o_tuser,
    output logic                    o_tlast,
    output logic                    o_tvalid,
    input  logic                    i_tready
);

    logic w_accept;

    // Ready only depends on our own register and downstream ready
    assign o_tready = !o_tvalid || i_tready;
    assign w_accept = i_tvalid && o_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_tdata  <= '0;
            o_tstrb  <= '0;
            o_tuser  <= '0;
            o_tlast  <= 1'b0;
            o_tvalid <= 1'b0;
        end else if (w_accept) begin
            o_tdata  <= i_tdata;
            o_tstrb  <= i_tstrb;
            o_tuser  <= i_tuser;
            o_tlast  <= i_tlast;
            o_tvalid <= 1'b1;
        end else if (i_tready) begin
            o_tvalid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/crypto_classifier.sv
// ============================================================================
// Module : crypto_classifier
// Brief  : Flags Ethernet/IPv4 packets for encryption in tuser[ENC_BIT].
//          Define CRYPTO_CLASSIFIER_STATS_EN to build the packet counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module crypto_classifier #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32,
    parameter int ENC_BIT              = crypto_pkg::ENC_BIT,
    parameter int NUM_RW_REGS          = 1,
    parameter int NUM_RO_REGS          = 2
) (
    input  logic                                    axi_aclk,
    input  logic                                    axi_aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]          s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]        s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]         s_axis_tuser,
    input  logic                                    s_axis_tvalid,
    output logic                                    s_axis_tready,
    input  logic                                    s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]        m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]         m_axis_tuser,
    output logic                                    m_axis_tvalid,
    input  logic                                    m_axis_tready,
    output logic                                    m_axis_tlast,
    input  logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0] rw_regs,
    output logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0] rw_defaults,
    output logic [NUM_RO_REGS*C_S_AXI_DATA_WIDTH-1:0] ro_regs
);

    import crypto_pkg::*;

    logic [0:0]                      r_state;
    logic                            r_flag;
    logic                            w_accept;
    logic                            w_match;
    logic                            w_enc;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] w_tuser;
    logic                            w_unused_ok;

    assign w_unused_ok = &{1'b0, rw_regs[NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:26]};
    assign rw_defaults = {{(NUM_RW_REGS*C_S_AXI_DATA_WIDTH-16){1'b0}}, DEFAULT_ETYPE};

    assign w_accept = s_axis_tvalid && s_axis_tready;

    // The protocol byte must actually be present in the header beat to match
    assign w_match = rw_regs[24]
                  && (s_axis_tdata[ETYPE_MSB:ETYPE_LSB] == rw_regs[15:0])
                  && (!rw_regs[25] || (s_axis_tdata[PROTO_MSB:PROTO_LSB] == rw_regs[23:16]))
                  && s_axis_tstrb[PROTO_STRB_IDX];

    assign w_enc = (r_state == HEAD) ? w_match : r_flag;

    always_comb begin
        w_tuser          = s_axis_tuser;
        w_tuser[ENC_BIT] = w_enc;
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state <= HEAD;
            r_flag  <= 1'b0;
        end else if (w_accept) begin
            if (r_state == HEAD) begin
                r_flag  <= w_match;
                r_state <= s_axis_tlast ? HEAD : BODY;
            end else if (s_axis_tlast) begin
                r_state <= HEAD;
            end
        end
    end

    axis_reg_slice #(
        .DATA_WIDTH (C_M_AXIS_DATA_WIDTH),
        .USER_WIDTH (C_M_AXIS_TUSER_WIDTH)
    ) u_slice (
        .clk      (axi_aclk),
        .rst_n    (axi_aresetn),
        .i_tdata  (s_axis_tdata),
        .i_tstrb  (s_axis_tstrb),
        .i_tuser  (w_tuser),
        .i_tlast  (s_axis_tlast),
        .i_tvalid (s_axis_tvalid),
        .o_tready (s_axis_tready),
        .o_tdata  (m_axis_tdata),
        .o_tstrb  (m_axis_tstrb),
        .o_tuser  (m_axis_tuser),
        .o_tlast  (m_axis_tlast),
        .o_tvalid (m_axis_tvalid),
        .i_tready (m_axis_tready)
    );

`ifdef CRYPTO_CLASSIFIER_STATS_EN
    logic [31:0] r_matched_cnt;
    logic [31:0] r_total_cnt;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_matched_cnt <= '0;
            r_total_cnt   <= '0;
        end else if (w_accept && (r_state == HEAD)) begin
            r_total_cnt <= r_total_cnt + 32'd1;
            if (w_match) begin
                r_matched_cnt <= r_matched_cnt + 32'd1;
            end
        end
    end

    assign ro_regs = {r_total_cnt, r_matched_cnt};
`else
    assign ro_regs = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crypto_classifier.sv
// ============================================================================
// Module : tb_crypto_classifier
// Brief  : Directed vector bench for crypto_classifier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_crypto_classifier;

    logic         clk = 1'b0;
    logic         axi_aresetn;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tstrb;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tstrb;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [31:0]  rw_regs;
    logic [31:0]  rw_defaults;
    logic [63:0]  ro_regs;

    always #5 clk = ~clk;

    crypto_classifier dut (
        .axi_aclk      (clk),
        .axi_aresetn   (axi_aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .rw_regs       (rw_regs),
        .rw_defaults   (rw_defaults),
        .ro_regs       (ro_regs)
    );

    typedef struct {
        logic [255:0] data;
        logic [31:0]  strb;
        logic [127:0] user;
        logic         last;
        logic [31:0]  rw;
        logic         exp_enc;
    } vec_t;

    localparam logic [31:0] CFG_A = 32'h0100_0800;
    localparam logic [31:0] CFG_B = 32'h0311_0800;
    localparam logic [31:0] CFG_Z = 32'h0000_0800;
    localparam logic [31:0] FULL  = 32'hFFFF_FFFF;
    localparam logic [127:0] U0   = 128'h0123_4567_89AB_CDEF_0000_0000_FEDC_BA98;
    localparam logic [127:0] U1   = 128'hDEAD_BEEF_0BAD_F00D_0000_0001_7654_3210;

    vec_t vecs[$];
    vec_t stall[4];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_total = 0;
    int   exp_matched = 0;

    function automatic logic [255:0] mk(input logic [15:0] et, input logic [7:0] pr,
                                        input logic [31:0] seed);
        logic [255:0] d;
        d = {8{32'h1357_9BDF ^ seed}};
        d[159:144] = et;
        d[71:64]   = pr;
        return d;
    endfunction

    function automatic vec_t v(input logic [255:0] d, input logic [31:0] s, input logic [127:0] u,
                               input logic l, input logic [31:0] rw, input logic e);
        vec_t r;
        r.data = d; r.strb = s; r.user = u; r.last = l; r.rw = rw; r.exp_enc = e;
        return r;
    endfunction

    function automatic logic [127:0] exp_user(input vec_t r);
        logic [127:0] u;
        u = r.user;
        u[32] = r.exp_enc;
        return u;
    endfunction

    function automatic logic [63:0] exp_ro();
`ifdef CRYPTO_CLASSIFIER_STATS_EN
        return {exp_total[31:0], exp_matched[31:0]};
`else
        return 64'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        s_axis_tdata  = r.data;
        s_axis_tstrb  = r.strb;
        s_axis_tuser  = r.user;
        s_axis_tlast  = r.last;
        rw_regs       = r.rw;
        s_axis_tvalid = 1'b1;
    endtask

    task automatic chk_beat(input string name, input vec_t r);
        chk({name, "_valid"}, m_axis_tvalid, 1'b1);
        chk({name, "_data"},  m_axis_tdata,  r.data);
        chk({name, "_strb"},  m_axis_tstrb,  r.strb);
        chk({name, "_last"},  m_axis_tlast,  r.last);
        chk({name, "_user"},  m_axis_tuser,  exp_user(r));
    endtask

    initial begin
        logic [255:0] held_data;
        logic [127:0] held_user;
        logic         prev_hold;
        logic         in_acc;
        logic         out_acc;
        int           in_i;
        int           out_i;

        axi_aresetn   = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        rw_regs       = CFG_A;

        vecs.push_back(v(mk(16'h0800, 8'h06, 1),  FULL, U0, 1'b0, CFG_A, 1'b1));
        vecs.push_back(v(mk(16'h0000, 8'h00, 2),  FULL, U1, 1'b1, CFG_A, 1'b1));
        vecs.push_back(v(mk(16'h0806, 8'h06, 3),  FULL, U1, 1'b0, CFG_A, 1'b0));
        vecs.push_back(v(mk(16'h0800, 8'h06, 4),  FULL, U1, 1'b1, CFG_A, 1'b0));
        vecs.push_back(v(mk(16'h0800, 8'h11, 5),  FULL, U0, 1'b0, CFG_B, 1'b1));
        vecs.push_back(v(mk(16'h0000, 8'h06, 6),  FULL, U0, 1'b1, CFG_B, 1'b1));
        vecs.push_back(v(mk(16'h0800, 8'h06, 7),  FULL, U1, 1'b0, CFG_B, 1'b0));
        vecs.push_back(v(mk(16'h0800, 8'h11, 8),  FULL, U1, 1'b1, CFG_B, 1'b0));
        vecs.push_back(v(mk(16'h0800, 8'h06, 9),  32'hFFFF_0000, U0, 1'b1, CFG_A, 1'b0));
        vecs.push_back(v(mk(16'h0800, 8'h06, 10), FULL, U0, 1'b1, CFG_A, 1'b1));
        vecs.push_back(v(mk(16'h0800, 8'h06, 11), FULL, U0, 1'b0, CFG_A, 1'b1));
        vecs.push_back(v(mk(16'h0806, 8'h01, 12), FULL, U0, 1'b0, CFG_Z, 1'b1));
        vecs.push_back(v(mk(16'h0000, 8'h00, 13), FULL, U0, 1'b1, CFG_Z, 1'b1));
        vecs.push_back(v(mk(16'h0800, 8'h06, 14), FULL, U1, 1'b1, CFG_Z, 1'b0));

        for (int k = 0; k < 4; k++) begin
            stall[k] = v(mk(16'h0800, 8'h06, 32'h40 + k), FULL, U0, (k == 3), CFG_A, 1'b1);
        end

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tdata",  m_axis_tdata,  256'd0);
        chk("rst_tuser",  m_axis_tuser,  128'd0);
        chk("rst_tstrb",  m_axis_tstrb,  32'd0);
        chk("rst_tlast",  m_axis_tlast,  1'b0);
        chk("rst_sready", s_axis_tready, 1'b1);
        chk("rw_defaults", rw_defaults,  32'h0000_0800);
        chk("rst_ro",     ro_regs,       64'd0);
        axi_aresetn = 1'b1;
        @(negedge clk);

        // Back-to-back table: each beat appears one cycle after it is offered
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk);
            @(negedge clk);
            chk_beat($sformatf("vec%0d", i), vecs[i]);
        end
        s_axis_tvalid = 1'b0;
        exp_total = 8;
        exp_matched = 4;
        chk("ro_after_table", ro_regs, exp_ro());
        @(posedge clk);
        @(negedge clk);
        chk("idle_tvalid", m_axis_tvalid, 1'b0);

        // Downstream ready toggling every cycle over a 4-beat packet
        in_i = 0;
        out_i = 0;
        prev_hold = 1'b0;
        held_data = '0;
        held_user = '0;
        for (int cyc = 0; cyc < 40 && out_i < 4; cyc++) begin
            m_axis_tready = (cyc % 2 == 0);
            if (in_i < 4) drive(stall[in_i]);
            else s_axis_tvalid = 1'b0;
            #1;
            if (prev_hold) begin
                chk("stall_hold_data", m_axis_tdata, held_data);
                chk("stall_hold_user", m_axis_tuser, held_user);
                chk("stall_hold_valid", m_axis_tvalid, 1'b1);
            end
            chk("stall_sready", s_axis_tready, !(m_axis_tvalid && !m_axis_tready));
            in_acc  = s_axis_tvalid && s_axis_tready;
            out_acc = m_axis_tvalid && m_axis_tready;
            if (out_acc) begin
                chk_beat($sformatf("stall_out%0d", out_i), stall[out_i]);
                out_i++;
            end
            prev_hold = m_axis_tvalid && !m_axis_tready;
            held_data = m_axis_tdata;
            held_user = m_axis_tuser;
            @(posedge clk);
            if (in_acc) in_i++;
            @(negedge clk);
        end
        chk("stall_beat_count", out_i, 4);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("stall_drain", m_axis_tvalid, 1'b0);
        exp_total = 9;
        exp_matched = 5;
        chk("ro_after_stall", ro_regs, exp_ro());

        // Reset in the middle of a matched packet
        drive(v(mk(16'h0800, 8'h06, 32'h50), FULL, U0, 1'b0, CFG_A, 1'b1));
        @(posedge clk);
        @(negedge clk);
        chk("mid_hdr_valid", m_axis_tvalid, 1'b1);
        drive(v(mk(16'h0000, 8'h00, 32'h51), FULL, U0, 1'b0, CFG_A, 1'b1));
        axi_aresetn = 1'b0;
        #1;
        chk("mid_rst_valid", m_axis_tvalid, 1'b0);
        chk("mid_rst_ro", ro_regs, 64'd0);
        @(negedge clk);
        axi_aresetn = 1'b1;
        drive(v(mk(16'h0806, 8'h06, 32'h52), FULL, U1, 1'b1, CFG_A, 1'b0));
        @(posedge clk);
        @(negedge clk);
        chk_beat("post_rst", v(mk(16'h0806, 8'h06, 32'h52), FULL, U1, 1'b1, CFG_A, 1'b0));
        s_axis_tvalid = 1'b0;
        exp_total = 1;
        exp_matched = 0;
        chk("ro_post_rst", ro_regs, exp_ro());

`ifdef CRYPTO_CLASSIFIER_STATS_EN
        // Total counter wraps from all-ones to zero
        force dut.r_total_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_total_cnt;
        drive(v(mk(16'h0800, 8'h06, 32'h60), FULL, U0, 1'b1, CFG_A, 1'b1));
        @(posedge clk);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        chk("wrap_ro", ro_regs, {32'd0, 32'd1});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
